udma_tx_lin_arbiter: RTL and testbench

Sits directly upstream of the TX linear channel bank. It arbitrates L2 read requests from the N_TX_LIN_CHANNELS linear TX channels and issues one request at a time to the L2 port. Channel index equals the TX linear channel ID from the uDMA configuration package: UART 0, QSPIM 1, QSPIM cmd 2, I2C 3-4, I2C cmd 5-6, HYPER 7. The block tracks outstanding reads in order and routes each read response, byte-aligned, back to the channel that issued it.

---
 rtl/udma_tx_lin_arbiter_if.sv | 33 +++
 rtl/udma_tx_lin_arbiter.sv | 138 +++++++++++++
 tb/tb_udma_tx_lin_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udma_tx_lin_arbiter_if.sv
// Bus bundle between the TX linear channels, the arbiter and the L2 read port.
//   ch_req_i / ch_addr_i       : per-channel read request and byte address
//   ch_gnt_o                   : one-hot grant pulse back to the channels
//   ch_r_valid_o / ch_r_data_o : one-hot response strobe and aligned data
//   l2_req_o / l2_addr_o       : single request towards L2 (word address)
//   l2_gnt_i                   : L2 accepts the request
//   l2_r_valid_i / l2_r_data_i : in-order L2 read data
// master = arbiter side, slave = channels/L2 side.
interface udma_tx_lin_arbiter_if #(
    parameter int N_CH      = 8,
    parameter int L2_AWIDTH = 32
);
    logic [N_CH-1:0]                ch_req_i;
    logic [N_CH-1:0][L2_AWIDTH-1:0] ch_addr_i;
    logic [N_CH-1:0]                ch_gnt_o;
    logic [N_CH-1:0]                ch_r_valid_o;
    logic [31:0]                    ch_r_data_o;
    logic                           l2_req_o;
    logic [L2_AWIDTH-1:0]           l2_addr_o;
    logic                           l2_gnt_i;
    logic                           l2_r_valid_i;
    logic [31:0]                    l2_r_data_i;

    modport master (
        input  ch_req_i, ch_addr_i, l2_gnt_i, l2_r_valid_i, l2_r_data_i,
        output ch_gnt_o, ch_r_valid_o, ch_r_data_o, l2_req_o, l2_addr_o
    );

    modport slave (
        output ch_req_i, ch_addr_i, l2_gnt_i, l2_r_valid_i, l2_r_data_i,
        input  ch_gnt_o, ch_r_valid_o, ch_r_data_o, l2_req_o, l2_addr_o
    );
endinterface

// File: rtl/udma_tx_lin_arbiter.sv
// Round-robin arbiter for the TX linear channel L2 read requests.
// One request is in flight towards L2 at a time; accepted requests are
// remembered in an in-order FIFO of {channel id, byte offset} so each read
// response is routed back, byte-aligned, to the channel that issued it.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   bus            : channel and L2 handshake bundle (master modport)
//   outstanding_o  : number of accepted reads awaiting a response
//   err_o          : sticky flag, set by a response with nothing outstanding
module udma_tx_lin_arbiter #(
    parameter int N_CH            = 8,
    parameter int L2_AWIDTH       = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    udma_tx_lin_arbiter_if.master              bus,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               err_o
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW    = $clog2(MAX_OUTSTANDING);
    localparam int OCC_W = PW + 1;
    localparam logic [OCC_W-1:0] MAX_OCC  = OCC_W'(MAX_OUTSTANDING);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);
    localparam logic [N_CH-1:0]  ONE_HOT0 = N_CH'(1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t               state_q, state_d;
    logic [CH_W-1:0]      rr_ptr_q;
    logic [CH_W-1:0]      win;
    logic                 found;
    logic                 arb;
    logic                 push, pop, spurious;

    logic                 l2_req_q;
    logic [L2_AWIDTH-1:0] l2_addr_q;
    logic [CH_W-1:0]      id_q;
    logic [1:0]           off_q;

    logic [CH_W-1:0]      fifo_id  [MAX_OUTSTANDING];
    logic [1:0]           fifo_off [MAX_OUTSTANDING];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]     count_q;

    logic [N_CH-1:0]      r_valid_q;
    logic [31:0]          r_data_q;
    logic                 err_q;

    // First requester at or above rr_ptr, wrapping around the channel ring.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_CH; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % N_CH;
            if (!found && bus.ch_req_i[idx]) begin
                found = 1'b1;
                win   = CH_W'(idx);
            end
        end
    end

    assign arb      = (state_q == IDLE) && found && (count_q < MAX_OCC);
    assign push     = (state_q == REQ) && bus.l2_gnt_i;
    // A response with an empty FIFO is dropped; a push in the same cycle
    // does not make it routable since the slot is not yet visible.
    assign pop      = bus.l2_r_valid_i && (count_q != '0);
    assign spurious = bus.l2_r_valid_i && (count_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb)         state_d = REQ;
            REQ:     if (bus.l2_gnt_i) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            l2_req_q  <= 1'b0;
            l2_addr_q <= '0;
            id_q      <= '0;
            off_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            r_valid_q <= '0;
            r_data_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            l2_req_q <= (state_d == REQ);

            if (arb) begin
                l2_addr_q <= {bus.ch_addr_i[win][L2_AWIDTH-1:2], 2'b00};
                id_q      <= win;
                off_q     <= bus.ch_addr_i[win][1:0];
                rr_ptr_q  <= (win == LAST_CH) ? '0 : win + 1'b1;
            end

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            r_valid_q <= pop ? (ONE_HOT0 << fifo_id[rd_ptr_q]) : '0;
            if (pop)
                r_data_q <= bus.l2_r_data_i >> {fifo_off[rd_ptr_q], 3'b000};

            if (spurious) err_q <= 1'b1;
        end
    end

    // Payload storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_id[wr_ptr_q]  <= id_q;
            fifo_off[wr_ptr_q] <= off_q;
        end
    end

    assign bus.ch_gnt_o     = arb ? (ONE_HOT0 << win) : '0;
    assign bus.ch_r_valid_o = r_valid_q;
    assign bus.ch_r_data_o  = r_data_q;
    assign bus.l2_req_o     = l2_req_q;
    assign bus.l2_addr_o    = l2_addr_q;
    assign outstanding_o    = count_q;
    assign err_o            = err_q;
endmodule

// File: tb/tb_udma_tx_lin_arbiter.sv
module tb_udma_tx_lin_arbiter;
    localparam int N_CH = 8;
    localparam int AW   = 32;
    localparam int MAXO = 4;

    logic       clk;
    logic       rst;
    logic [2:0] outstanding;
    logic       err;

    udma_tx_lin_arbiter_if #(.N_CH(N_CH), .L2_AWIDTH(AW)) bus ();

    udma_tx_lin_arbiter #(.N_CH(N_CH), .L2_AWIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus           (bus),
        .outstanding_o (outstanding),
        .err_o         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queue of pending reads plus the scalar arbiter view.
    int          m_rr;
    bit          m_pend;
    int          m_pid, m_poff;
    logic [31:0] m_addr;
    bit          m_req;
    logic [7:0]  m_rv;
    logic [31:0] m_rd;
    bit          m_err;
    int          q_id[$];
    int          q_off[$];

    logic [7:0]  pre_gnt;
    int          gnt_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (m_pend || q_id.size() >= MAXO) return -1;
        for (int k = 0; k < N_CH; k++) begin
            int c;
            c = (m_rr + k) % N_CH;
            if (bus.ch_req_i[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_pend = 0; m_pid = 0; m_poff = 0; m_addr = '0; m_req = 0;
        m_rv = '0; m_rd = '0; m_err = 0;
        q_id.delete(); q_off.delete();
    endtask

    task automatic model_update();
        int w;
        w = model_grant();
        m_rv = '0;
        if (bus.l2_r_valid_i) begin
            if (q_id.size() > 0) begin
                int id, off;
                id  = q_id.pop_front();
                off = q_off.pop_front();
                m_rv = 8'(1 << id);
                m_rd = bus.l2_r_data_i >> (8 * off);
            end else begin
                m_err = 1;
            end
        end
        if (m_pend && bus.l2_gnt_i) begin
            q_id.push_back(m_pid);
            q_off.push_back(m_poff);
            m_pend = 0;
            m_req  = 0;
        end else if (w >= 0) begin
            logic [31:0] a;
            a      = bus.ch_addr_i[w];
            m_pend = 1;
            m_pid  = w;
            m_poff = int'(a[1:0]);
            m_addr = {a[31:2], 2'b00};
            m_rr   = (w + 1) % N_CH;
            m_req  = 1;
        end
    endtask

    function automatic int oh_idx(input logic [7:0] v);
        for (int i = 0; i < N_CH; i++) if (v[i]) return i;
        return -1;
    endfunction

    // One clock: entered at posedge+1 with inputs applied; compares against
    // the model mid-cycle, advances the model at the edge, returns at +1.
    task automatic cycle();
        int w;
        #5;
        w = model_grant();
        pre_gnt = bus.ch_gnt_o;
        chk("gnt",     {24'd0, bus.ch_gnt_o}, (w >= 0) ? 32'(1 << w) : 32'd0);
        chk("l2_req",  {31'd0, bus.l2_req_o}, {31'd0, m_req});
        chk("l2_addr", bus.l2_addr_o, m_addr);
        chk("r_valid", {24'd0, bus.ch_r_valid_o}, {24'd0, m_rv});
        chk("r_data",  bus.ch_r_data_o, m_rd);
        chk("occ",     {29'd0, outstanding}, 32'(q_id.size()));
        chk("err",     {31'd0, err}, {31'd0, m_err});
        if (pre_gnt != 0) gnt_log.push_back(oh_idx(pre_gnt));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        bus.ch_req_i     = '0;
        bus.l2_gnt_i     = 1'b0;
        bus.l2_r_valid_i = 1'b0;
        bus.l2_r_data_i  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        chk("rst_gnt",  {24'd0, bus.ch_gnt_o}, 32'd0);
        chk("rst_req",  {31'd0, bus.l2_req_o}, 32'd0);
        chk("rst_addr", bus.l2_addr_o, 32'd0);
        chk("rst_rv",   {24'd0, bus.ch_r_valid_o}, 32'd0);
        chk("rst_rd",   bus.ch_r_data_o, 32'd0);
        chk("rst_occ",  {29'd0, outstanding}, 32'd0);
        chk("rst_err",  {31'd0, err}, 32'd0);
        model_reset();
        gnt_log.delete();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic [7:0]  e_gnt;
        logic        e_req;
        logic [31:0] e_addr;
        logic [7:0]  e_rv;
        logic [31:0] e_rd;
        int          e_occ;
    } vec_t;

    vec_t tv[4];

    initial begin
        tv[0] = '{8'h08, 1'b0, 1'b0, 32'h0,        8'h08, 1'b1, 32'h1C000004, 8'h00, 32'h0,        0};
        tv[1] = '{8'h00, 1'b1, 1'b0, 32'h0,        8'h00, 1'b0, 32'h1C000004, 8'h00, 32'h0,        1};
        tv[2] = '{8'h00, 1'b0, 1'b1, 32'hAABBCCDD, 8'h00, 1'b0, 32'h1C000004, 8'h08, 32'h0000AABB, 0};
        tv[3] = '{8'h00, 1'b0, 1'b0, 32'h0,        8'h00, 1'b0, 32'h1C000004, 8'h00, 32'h0000AABB, 0};

        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < N_CH; i++) bus.ch_addr_i[i] = 32'h1C000100 + 32'(i * 16);
        #2;
        do_reset();

        // Single-channel read with offset 2 on channel 3.
        bus.ch_addr_i[3] = 32'h1C000006;
        foreach (tv[i]) begin
            bus.ch_req_i     = tv[i].req;
            bus.l2_gnt_i     = tv[i].gnt;
            bus.l2_r_valid_i = tv[i].rv;
            bus.l2_r_data_i  = tv[i].rd;
            cycle();
            chk($sformatf("t1_gnt[%0d]", i),  {24'd0, pre_gnt}, {24'd0, tv[i].e_gnt});
            chk($sformatf("t1_req[%0d]", i),  {31'd0, bus.l2_req_o}, {31'd0, tv[i].e_req});
            chk($sformatf("t1_addr[%0d]", i), bus.l2_addr_o, tv[i].e_addr);
            chk($sformatf("t1_rv[%0d]", i),   {24'd0, bus.ch_r_valid_o}, {24'd0, tv[i].e_rv});
            chk($sformatf("t1_rd[%0d]", i),   bus.ch_r_data_o, tv[i].e_rd);
            chk($sformatf("t1_occ[%0d]", i),  {29'd0, outstanding}, 32'(tv[i].e_occ));
        end

        // Round-robin fairness with all channels requesting.
        do_reset();
        bus.ch_req_i = 8'hFF;
        bus.l2_gnt_i = 1'b1;
        for (int c = 0; c < 40 && gnt_log.size() < 9; c++) begin
            bus.l2_r_valid_i = (q_id.size() > 0);
            bus.l2_r_data_i  = $urandom;
            cycle();
        end
        chk("t2_count", 32'(gnt_log.size()), 32'd9);
        for (int i = 0; i < 9 && i < gnt_log.size(); i++)
            chk($sformatf("t2_order[%0d]", i), 32'(gnt_log[i]), 32'(i % 8));

        // Pointer wrap: move rr_ptr to 6, then requests on 2 and 7.
        do_reset();
        bus.ch_req_i = 8'h20; cycle();
        bus.ch_req_i = 8'h00; bus.l2_gnt_i = 1'b1; cycle();
        bus.l2_gnt_i = 1'b0; bus.l2_r_valid_i = 1'b1; cycle();
        bus.l2_r_valid_i = 1'b0;
        gnt_log.delete();
        bus.l2_gnt_i = 1'b1;
        for (int c = 0; c < 30 && gnt_log.size() < 3; c++) begin
            bus.ch_req_i     = (gnt_log.size() < 2) ? 8'h84 : 8'hFF;
            bus.l2_r_valid_i = (q_id.size() > 0);
            cycle();
        end
        chk("t3_count", 32'(gnt_log.size()), 32'd3);
        if (gnt_log.size() >= 3) begin
            chk("t3_first",  32'(gnt_log[0]), 32'd7);
            chk("t3_second", 32'(gnt_log[1]), 32'd2);
            chk("t3_rr_end", 32'(gnt_log[2]), 32'd3);
        end

        // FIFO full: four grants without responses stall arbitration.
        do_reset();
        bus.ch_req_i = 8'hFF;
        bus.l2_gnt_i = 1'b1;
        for (int c = 0; c < 20 && gnt_log.size() < 4; c++) cycle();
        cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t4_occ_full", {29'd0, outstanding}, 32'd4);
            chk("t4_no_gnt",   {24'd0, bus.ch_gnt_o}, 32'd0);
        end
        bus.l2_r_valid_i = 1'b1;
        cycle();
        bus.l2_r_valid_i = 1'b0;
        chk("t4_gnt_after_pop", {31'd0, (bus.ch_gnt_o != 0)}, 32'd1);
        chk("t4_occ_after_pop", {29'd0, outstanding}, 32'd3);
        bus.ch_req_i = 8'h00;
        for (int c = 0; c < 8; c++) begin
            bus.l2_r_valid_i = (q_id.size() > 0);
            cycle();
        end

        // Push and pop in the same cycle at occupancy 2.
        do_reset();
        bus.ch_addr_i[0] = 32'h1C000201;
        bus.ch_addr_i[1] = 32'h1C000302;
        bus.ch_addr_i[2] = 32'h1C000403;
        bus.ch_req_i = 8'h01; cycle();
        bus.ch_req_i = 8'h00; bus.l2_gnt_i = 1'b1; cycle();
        bus.ch_req_i = 8'h02; bus.l2_gnt_i = 1'b0; cycle();
        bus.ch_req_i = 8'h00; bus.l2_gnt_i = 1'b1; cycle();
        chk("t5_occ2", {29'd0, outstanding}, 32'd2);
        bus.ch_req_i = 8'h04; bus.l2_gnt_i = 1'b0; cycle();
        bus.ch_req_i = 8'h00; bus.l2_gnt_i = 1'b1;
        bus.l2_r_valid_i = 1'b1; bus.l2_r_data_i = 32'h11223344; cycle();
        chk("t5_occ_same", {29'd0, outstanding}, 32'd2);
        chk("t5_rv0", {24'd0, bus.ch_r_valid_o}, 32'h01);
        chk("t5_rd0", bus.ch_r_data_o, 32'h00112233);
        bus.l2_gnt_i = 1'b0; bus.l2_r_data_i = 32'h55667788; cycle();
        chk("t5_rv1", {24'd0, bus.ch_r_valid_o}, 32'h02);
        chk("t5_rd1", bus.ch_r_data_o, 32'h00005566);
        bus.l2_r_data_i = 32'h99AABBCC; cycle();
        chk("t5_rv2", {24'd0, bus.ch_r_valid_o}, 32'h04);
        chk("t5_rd2", bus.ch_r_data_o, 32'h00000099);
        bus.l2_r_valid_i = 1'b0; cycle();
        chk("t5_occ0", {29'd0, outstanding}, 32'd0);
        chk("t5_rd_hold", bus.ch_r_data_o, 32'h00000099);

        // Spurious response, then asynchronous reset mid-request.
        do_reset();
        bus.l2_r_valid_i = 1'b1; bus.l2_r_data_i = 32'hDEADBEEF; cycle();
        bus.l2_r_valid_i = 1'b0;
        chk("t6_err_set", {31'd0, err}, 32'd1);
        chk("t6_no_rv",   {24'd0, bus.ch_r_valid_o}, 32'd0);
        cycle(); cycle();
        chk("t6_err_sticky", {31'd0, err}, 32'd1);
        bus.ch_req_i = 8'h10; cycle();
        bus.ch_req_i = 8'h00; cycle();
        chk("t6_in_req", {31'd0, bus.l2_req_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_async_req", {31'd0, bus.l2_req_o}, 32'd0);
        chk("t6_async_err", {31'd0, err}, 32'd0);
        chk("t6_async_occ", {29'd0, outstanding}, 32'd0);
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // Randomized traffic against the reference model.
        for (int blk = 0; blk < 3; blk++) begin
            do_reset();
            for (int c = 0; c < 600; c++) begin
                bus.ch_req_i = 8'($urandom);
                for (int i = 0; i < N_CH; i++) bus.ch_addr_i[i] = $urandom;
                bus.l2_gnt_i     = ($urandom_range(0, 2) != 0);
                bus.l2_r_valid_i = ((q_id.size() > 0) && ($urandom_range(0, 2) == 0))
                                   || ($urandom_range(0, 99) == 0);
                bus.l2_r_data_i  = $urandom;
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
